// File: rtl/tag_memory_nway.sv
// N-way set-associative tag store with true-LRU replacement and per-line valid/dirty state.
// Optional hit/miss counters are enabled by defining TAG_MEMORY_NWAY_STATS_EN.
module tag_memory_nway #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int N_WAY                = 4,
    parameter int BW_TAG               = 20,
    localparam int NUM_SETS            = CACHE_BLOCK_CAPACITY / N_WAY,
    localparam int BW_SET              = $clog2(NUM_SETS),
    localparam int BW_WAY              = $clog2(N_WAY)
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
`ifdef TAG_MEMORY_NWAY_STATS_EN
    input  logic                     stat_clr_i,
    output logic [31:0]              stat_hit_o,
    output logic [31:0]              stat_miss_o,
`endif
    output logic                     init_done_o,
    input  logic                     req_i,
    input  logic [1:0]               op_i,
    input  logic                     rw_i,
    input  logic [BW_TAG-1:0]        tag_i,
    input  logic [BW_SET-1:0]        set_i,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     hit_o,
    output logic [BW_SET+BW_WAY-1:0] addr_o,
    output logic [BW_TAG-1:0]        victim_tag_o,
    output logic                     victim_valid_o,
    output logic                     victim_dirty_o
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_COMPARE} state_e;
    typedef enum logic [1:0] {OP_LOOKUP, OP_FILL, OP_INVAL, OP_PROBE} op_e;

    state_e              state_q;
    op_e                 op_q;
    logic                rw_q;
    logic [BW_TAG-1:0]   req_tag_q;
    logic [BW_SET-1:0]   set_q;
    logic [BW_SET-1:0]   cnt_q;
    logic                ready_q, init_done_q, done_q, hit_q;
    logic [BW_SET+BW_WAY-1:0] addr_q;
    logic [BW_TAG-1:0]   vtag_q;
    logic                vvalid_q, vdirty_q;

    logic [BW_TAG-1:0]   tag_mem_q [NUM_SETS][N_WAY];
    logic [N_WAY-1:0]    valid_q   [NUM_SETS];
    logic [N_WAY-1:0]    dirty_q   [NUM_SETS];
    logic [BW_WAY-1:0]   age_q     [NUM_SETS][N_WAY];

    logic [N_WAY-1:0]    hit_vec;
    logic                cmp_hit, hit_found, any_inv, fill_miss;
    logic [BW_WAY-1:0]   hit_way, inv_way, lru_way, victim_way, tgt_way, old_age;
    logic [BW_WAY-1:0]   promote_age [N_WAY];
    logic [BW_WAY-1:0]   demote_age  [N_WAY];
    logic                vvalid_d, vdirty_d;
    logic [BW_TAG-1:0]   vtag_d;

    always_comb begin
        hit_vec   = '0;
        hit_way   = '0;
        hit_found = 1'b0;
        inv_way   = '0;
        any_inv   = 1'b0;
        lru_way   = '0;
        for (int unsigned w = 0; w < N_WAY; w++) begin
            hit_vec[w] = valid_q[set_q][w] && (tag_mem_q[set_q][w] == req_tag_q);
            if (hit_vec[w] && !hit_found) begin
                hit_way   = BW_WAY'(w);
                hit_found = 1'b1;
            end
            if (!valid_q[set_q][w] && !any_inv) begin
                inv_way = BW_WAY'(w);
                any_inv = 1'b1;
            end
            if (age_q[set_q][w] == BW_WAY'(N_WAY - 1))
                lru_way = BW_WAY'(w);
        end
        cmp_hit    = |hit_vec;
        victim_way = any_inv ? inv_way : lru_way;
        fill_miss  = (op_q == OP_FILL) && !cmp_hit;
        tgt_way    = cmp_hit ? hit_way : (fill_miss ? victim_way : '0);
        old_age    = age_q[set_q][tgt_way];
        // Promotion and demotion both keep each set's ages a permutation of 0..N_WAY-1.
        for (int unsigned w = 0; w < N_WAY; w++) begin
            if (BW_WAY'(w) == tgt_way) begin
                promote_age[w] = '0;
                demote_age[w]  = BW_WAY'(N_WAY - 1);
            end else begin
                promote_age[w] = (age_q[set_q][w] < old_age) ? age_q[set_q][w] + 1'b1 : age_q[set_q][w];
                demote_age[w]  = (age_q[set_q][w] > old_age) ? age_q[set_q][w] - 1'b1 : age_q[set_q][w];
            end
        end
        vvalid_d = fill_miss && valid_q[set_q][victim_way];
        vdirty_d = vvalid_d && dirty_q[set_q][victim_way];
        vtag_d   = vvalid_d ? tag_mem_q[set_q][victim_way] : '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            op_q        <= OP_LOOKUP;
            rw_q        <= 1'b0;
            req_tag_q   <= '0;
            set_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            addr_q      <= '0;
            vtag_q      <= '0;
            vvalid_q    <= 1'b0;
            vdirty_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    valid_q[cnt_q] <= '0;
                    dirty_q[cnt_q] <= '0;
                    for (int unsigned w = 0; w < N_WAY; w++)
                        age_q[cnt_q][w] <= BW_WAY'(w);
                    if (cnt_q == BW_SET'(NUM_SETS - 1)) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + BW_SET'(1);
                    end
                end
                S_IDLE: begin
                    if (req_i && ready_q) begin
                        op_q      <= op_e'(op_i);
                        rw_q      <= rw_i;
                        req_tag_q <= tag_i;
                        set_q     <= set_i;
                        ready_q   <= 1'b0;
                        state_q   <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    done_q   <= 1'b1;
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                    hit_q    <= cmp_hit && (op_q != OP_FILL);
                    addr_q   <= {set_q, tgt_way};
                    vtag_q   <= vtag_d;
                    vvalid_q <= vvalid_d;
                    vdirty_q <= vdirty_d;
                    case (op_q)
                        OP_LOOKUP, OP_FILL: begin
                            if (cmp_hit || fill_miss) begin
                                for (int unsigned w = 0; w < N_WAY; w++)
                                    age_q[set_q][w] <= promote_age[w];
                            end
                            if (cmp_hit && rw_q)
                                dirty_q[set_q][hit_way] <= 1'b1;
                            if (fill_miss) begin
                                tag_mem_q[set_q][victim_way] <= req_tag_q;
                                valid_q[set_q][victim_way]   <= 1'b1;
                                dirty_q[set_q][victim_way]   <= rw_q;
                            end
                        end
                        OP_INVAL: begin
                            if (cmp_hit) begin
                                valid_q[set_q][hit_way] <= 1'b0;
                                dirty_q[set_q][hit_way] <= 1'b0;
                                for (int unsigned w = 0; w < N_WAY; w++)
                                    age_q[set_q][w] <= demote_age[w];
                            end
                        end
                        OP_PROBE: ;
                    endcase
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign init_done_o    = init_done_q;
    assign ready_o        = ready_q;
    assign done_o         = done_q;
    assign hit_o          = hit_q;
    assign addr_o         = addr_q;
    assign victim_tag_o   = vtag_q;
    assign victim_valid_o = vvalid_q;
    assign victim_dirty_o = vdirty_q;

`ifdef TAG_MEMORY_NWAY_STATS_EN
    logic [31:0] stat_hit_q, stat_miss_q;

    // Counted on the edge that registers done_o, so the counters move with the pulse.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else if (stat_clr_i) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else if (state_q == S_COMPARE && op_q == OP_LOOKUP) begin
            if (cmp_hit) begin
                if (stat_hit_q != '1) stat_hit_q <= stat_hit_q + 32'd1;
            end else begin
                if (stat_miss_q != '1) stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end

    assign stat_hit_o  = stat_hit_q;
    assign stat_miss_o = stat_miss_q;
`else
    // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_tag_memory_nway.sv
// Directed scoreboard bench for tag_memory_nway (128 lines, 4 ways, 20-bit tags).
module tb_tag_memory_nway;
    localparam logic [1:0] LK = 2'd0, FL = 2'd1, IV = 2'd2, PR = 2'd3;

    logic        clk = 1'b0;
    logic        rst, req, rw;
    logic [1:0]  op;
    logic [19:0] tag;
    logic [4:0]  set;
    logic        init_done, ready, done, hit, vvalid, vdirty;
    logic [6:0]  addr;
    logic [19:0] vtag;
`ifdef TAG_MEMORY_NWAY_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_hit, stat_miss;
`endif

    typedef struct {
        logic        hit;
        logic [6:0]  addr;
        logic [19:0] vtag;
        logic        vvalid;
        logic        vdirty;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    tag_memory_nway #(.CACHE_BLOCK_CAPACITY(128), .N_WAY(4), .BW_TAG(20)) dut (
        .clock_i(clk), .reset_i(rst),
`ifdef TAG_MEMORY_NWAY_STATS_EN
        .stat_clr_i(stat_clr), .stat_hit_o(stat_hit), .stat_miss_o(stat_miss),
`endif
        .init_done_o(init_done), .req_i(req), .op_i(op), .rw_i(rw), .tag_i(tag), .set_i(set),
        .ready_o(ready), .done_o(done), .hit_o(hit), .addr_o(addr),
        .victim_tag_o(vtag), .victim_valid_o(vvalid), .victim_dirty_o(vdirty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] s, input logic h, input logic [1:0] w,
                        input logic [19:0] vt, input logic vv, input logic vd);
        exp_t e;
        e.hit = h; e.addr = {s, w}; e.vtag = vt; e.vvalid = vv; e.vdirty = vd;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic r, input logic [19:0] t, input logic [4:0] s);
        int n = 0;
        req = 1'b1; op = o; rw = r; tag = t; set = s;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) chk("accept_timeout", 32'(ready), 32'd1);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        int n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        if (!done) begin
            chk("done_timeout", 32'(done), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            chk("hit", 32'(hit), 32'(e.hit));
            chk("addr", 32'(addr), 32'(e.addr));
            chk("victim_tag", 32'(vtag), 32'(e.vtag));
            chk("victim_valid", 32'(vvalid), 32'(e.vvalid));
            chk("victim_dirty", 32'(vdirty), 32'(e.vdirty));
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
        end
    endtask

    task automatic txn(input logic [1:0] o, input logic r, input logic [19:0] t, input logic [4:0] s,
                       input logic h, input logic [1:0] w, input logic [19:0] vt,
                       input logic vv, input logic vd);
        push(s, h, w, vt, vv, vd);
        issue(o, r, t, s);
        collect();
    endtask

    task automatic wait_init();
        int n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        chk("init_cycles", 32'(n), 32'd32);
        chk("init_done", 32'(init_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; op = LK; rw = 1'b0; tag = '0; set = '0;
`ifdef TAG_MEMORY_NWAY_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Request held through INIT; it is only accepted once ready_o rises.
        rst = 1'b0;
        req = 1'b1; op = LK; rw = 1'b0; tag = 20'h55; set = 5'd5;
        push(5'd5, 1'b0, 2'd0, 20'h0, 1'b0, 1'b0);
        wait_init();
        @(negedge clk);
        req = 1'b0;
        collect();

        txn(FL, 0, 20'hA, 3, 0, 0, 20'h0, 0, 0);
        txn(FL, 0, 20'hB, 3, 0, 1, 20'h0, 0, 0);
        txn(FL, 0, 20'hC, 3, 0, 2, 20'h0, 0, 0);
        txn(FL, 0, 20'hD, 3, 0, 3, 20'h0, 0, 0);
        txn(LK, 0, 20'hC, 3, 1, 2, 20'h0, 0, 0);
        txn(LK, 1, 20'hA, 3, 1, 0, 20'h0, 0, 0);
        txn(FL, 0, 20'hE, 3, 0, 1, 20'hB, 1, 0);
        txn(LK, 0, 20'hD, 3, 1, 3, 20'h0, 0, 0);
        txn(FL, 0, 20'hF, 3, 0, 2, 20'hC, 1, 0);
        txn(FL, 0, 20'h5, 3, 0, 0, 20'hA, 1, 1);
        txn(IV, 0, 20'hD, 3, 1, 3, 20'h0, 0, 0);
        txn(FL, 0, 20'h1, 3, 0, 3, 20'h0, 0, 0);
        txn(IV, 0, 20'h7, 3, 0, 0, 20'h0, 0, 0);
        txn(PR, 0, 20'hE, 3, 1, 1, 20'h0, 0, 0);
        txn(FL, 1, 20'h2, 3, 0, 1, 20'hE, 1, 0);
        txn(FL, 0, 20'hF, 3, 0, 2, 20'h0, 0, 0);
        txn(LK, 0, 20'hF, 3, 1, 2, 20'h0, 0, 0);
        txn(FL, 0, 20'h3, 3, 0, 0, 20'h5, 1, 0);
        txn(FL, 0, 20'h4, 3, 0, 3, 20'h1, 1, 0);
        txn(FL, 0, 20'h6, 3, 0, 1, 20'h2, 1, 1);
        txn(LK, 0, 20'h6, 4, 0, 0, 20'h0, 0, 0);
        txn(FL, 1, 20'hFFFFF, 31, 0, 0, 20'h0, 0, 0);
        txn(LK, 0, 20'hFFFFF, 31, 1, 0, 20'h0, 0, 0);
        txn(PR, 0, 20'hFFFFE, 31, 0, 0, 20'h0, 0, 0);

        // Abort a fill by resetting while it sits in COMPARE.
        issue(FL, 0, 20'h77, 7);
        rst = 1'b1;
        #1;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("abort_done_late", 32'(done), 32'd0);
        rst = 1'b0;
        wait_init();
        txn(LK, 0, 20'h77, 7, 0, 0, 20'h0, 0, 0);

`ifdef TAG_MEMORY_NWAY_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
`endif
        txn(FL, 0, 20'h9, 9, 0, 0, 20'h0, 0, 0);
        txn(LK, 0, 20'h9, 9, 1, 0, 20'h0, 0, 0);
        txn(LK, 0, 20'h9, 9, 1, 0, 20'h0, 0, 0);
        txn(LK, 0, 20'h8, 9, 0, 0, 20'h0, 0, 0);
        txn(PR, 0, 20'h9, 9, 1, 0, 20'h0, 0, 0);
        txn(LK, 0, 20'h9, 9, 1, 0, 20'h0, 0, 0);
        txn(LK, 0, 20'h8, 9, 0, 0, 20'h0, 0, 0);
`ifdef TAG_MEMORY_NWAY_STATS_EN
        chk("stat_hit", stat_hit, 32'd3);
        chk("stat_miss", stat_miss, 32'd2);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_hit_clr", stat_hit, 32'd0);
        chk("stat_miss_clr", stat_miss, 32'd0);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
